vaddsub_seq: RTL

Vector-op sequencer that sits directly upstream of the `vaddsub` lanes.
- Accepts one whole-vector fp16 add/sub request over a valid/ready handshake.
- Issues it to `LANES` parallel `vaddsub` instances, `LANES` elements per cycle.
- Tracks the fixed pipeline latency, gathers lane results and overflow flags into a result buffer, and returns the complete vector over a second valid/ready handshake.
- The `vaddsub` instances are external; this block drives their inputs and consumes their outputs.

---
 rtl/vector_pkg.sv | 26 ++
 rtl/lat_tracker.sv | 50 +++++
 rtl/vaddsub_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// vector_pkg
//   Shared definitions for the fp16 vector datapath blocks.
//   - FP16_W      : width of one fp16 element
//   - fp16_t      : one fp16 element
//   - seq_state_t : sequencer FSM states (IDLE, ISSUE, DRAIN, RESP)
//   - tag_width() : width needed to hold a beat index (at least 1 bit)
package vector_pkg;

   localparam int FP16_W = 16;

   typedef logic [FP16_W-1:0] fp16_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } seq_state_t;

   // A single-beat vector still needs a one-bit tag so that the tracker
   // and the beat counter never become zero-width.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lat_tracker.sv
// lat_tracker
//   Fixed-latency tag pipeline. A tag pushed in one cycle reaches the head
//   DEPTH cycles later, lining up with the lane result it belongs to.
//   Ports:
//     CLK, nRST          clock, synchronous active-low reset
//     push_valid/push_tag tag entering the pipe this cycle
//     head_valid/head_tag tag that is DEPTH cycles old
//     empty               no valid tag anywhere in the pipe
module lat_tracker
   import vector_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int TAG_W = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             push_valid,
   input  logic [TAG_W-1:0] push_tag,
   output logic             head_valid,
   output logic [TAG_W-1:0] head_tag,
   output logic             empty
);

   logic [DEPTH-1:0] vld;
   logic [TAG_W-1:0] tag [DEPTH];

   // Shift every cycle whether or not anything is pushed, so a slot's age
   // always equals its position. Reset drops every in-flight tag, which is
   // what makes lane results from an aborted operation harmless.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag[i] <= '0;
         end
      end else begin
         vld[0] <= push_valid;
         tag[0] <= push_tag;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
      end
   end

   assign head_valid = vld[DEPTH-1];
   assign head_tag   = tag[DEPTH-1];
   assign empty      = ~|vld;

endmodule

// File: rtl/vaddsub_seq.sv
// vaddsub_seq
//   Whole-vector fp16 add/sub sequencer in front of LANES external vaddsub
//   lanes. Accepts a request, issues LANES elements per cycle, gathers the
//   lane results after LAT cycles and returns the full vector.
//   Ports:
//     CLK, nRST                 clock, synchronous active-low reset
//     req_valid/req_ready       request handshake
//     req_sub, req_a, req_b     operation (1 = A-B) and operand vectors
//     resp_valid/resp_ready     response handshake
//     resp_out                  result vector (element i at [16i+:16])
//     resp_ovf, resp_ovf_mask   overflow summary and per-element flags
//     lane_en, lane_sub         lane enable and add/sub control
//     lane_a, lane_b            lane operands for the current beat
//     lane_out, lane_ovf        lane results and overflow flags
module vaddsub_seq
   import vector_pkg::*;
#(
   parameter int VLEN  = 16,
   parameter int LANES = 4,
   parameter int LAT   = 3
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_sub,
   input  logic [VLEN*FP16_W-1:0]  req_a,
   input  logic [VLEN*FP16_W-1:0]  req_b,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [VLEN*FP16_W-1:0]  resp_out,
   output logic                    resp_ovf,
   output logic [VLEN-1:0]         resp_ovf_mask,
   output logic                    lane_en,
   output logic                    lane_sub,
   output logic [LANES*FP16_W-1:0] lane_a,
   output logic [LANES*FP16_W-1:0] lane_b,
   input  logic [LANES*FP16_W-1:0] lane_out,
   input  logic [LANES-1:0]        lane_ovf
);

   localparam int BEATS  = VLEN / LANES;
   localparam int TAG_W  = tag_width(BEATS);
   localparam int BEAT_W = LANES * FP16_W;
   localparam logic [TAG_W-1:0] LAST_BEAT = TAG_W'(BEATS - 1);

   seq_state_t        state;
   logic [TAG_W-1:0]  beat;
   logic              sub_q;
   logic [BEAT_W-1:0] a_q   [BEATS];
   logic [BEAT_W-1:0] b_q   [BEATS];
   logic [BEAT_W-1:0] res_q [BEATS];
   logic [LANES-1:0]  ovf_q [BEATS];

   logic              issuing;
   logic              head_valid;
   logic [TAG_W-1:0]  head_tag;
   logic              trk_empty;
   logic              last_capture;

   assign issuing = (state == ISSUE);

   // The tracker carries each issued beat index down a LAT-deep pipe so the
   // head lines up with the lane outputs produced for that beat.
   lat_tracker #(
      .DEPTH (LAT),
      .TAG_W (TAG_W)
   ) u_tracker (
      .CLK        (CLK),
      .nRST       (nRST),
      .push_valid (issuing),
      .push_tag   (beat),
      .head_valid (head_valid),
      .head_tag   (head_tag),
      .empty      (trk_empty)
   );

   // The final beat is being captured on this edge, so after it the buffer
   // is complete; leaving DRAIN here gives the response one cycle after the
   // last capture without waiting for the tracker to shift out.
   assign last_capture = head_valid && (head_tag == LAST_BEAT);

   // FSM, beat counter, operand latch and result buffer. The capture is
   // written before the state case so that a new request's buffer clear
   // on acceptance always wins over anything the lanes present that cycle.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         beat  <= '0;
         sub_q <= 1'b0;
         for (int i = 0; i < BEATS; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            res_q[i] <= '0;
            ovf_q[i] <= '0;
         end
      end else begin
         if (head_valid) begin
            res_q[head_tag] <= lane_out;
            ovf_q[head_tag] <= lane_ovf;
         end

         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  sub_q <= req_sub;
                  beat  <= '0;
                  for (int i = 0; i < BEATS; i++) begin
                     a_q[i]   <= req_a[i*BEAT_W +: BEAT_W];
                     b_q[i]   <= req_b[i*BEAT_W +: BEAT_W];
                     res_q[i] <= '0;
                     ovf_q[i] <= '0;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (beat == LAST_BEAT) begin
                  beat  <= '0;
                  state <= DRAIN;
               end else begin
                  beat <= beat + TAG_W'(1);
               end
            end
            DRAIN: begin
               if (last_capture || trk_empty) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and lane drive are pure functions of state; lane operands
   // are forced to zero whenever no beat is being issued.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign lane_en    = issuing;
   assign lane_sub   = issuing & sub_q;
   assign lane_a     = issuing ? a_q[beat] : '0;
   assign lane_b     = issuing ? b_q[beat] : '0;

   // Flatten the per-beat buffers into the element-ordered response.
   for (genvar g = 0; g < BEATS; g++) begin : g_resp
      assign resp_out[g*BEAT_W +: BEAT_W]     = res_q[g];
      assign resp_ovf_mask[g*LANES +: LANES]  = ovf_q[g];
   end

   assign resp_ovf = |resp_ovf_mask;

endmodule
